// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width that never collapses to zero bits (e.g. a count limit of 1).
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_tick_gen.sv
// Per-bit cycle counter: tick marks the final clock a serial bit is held.
module bit_tick_gen
  import piso_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = clog2_min1(BIT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cyc;

  // With BIT_CYCLES=1 the counter sits at 0 and tick stays high.
  assign tick = (cyc == TERM);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cyc <= '0;
    end else if (en) begin
      cyc <= tick ? '0 : cyc + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a SISO chain.
// Handshake: a word transfers on a rising edge where din_valid & din_ready; din_ready never looks at din_valid.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   BIT_CYCLES = 1,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int IW = clog2_min1(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] PEN_IDX  = IW'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [IW-1:0]    bit_idx;
  logic             tick;
  logic             last;
  logic             load;

  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  always_comb begin
    sreg_shifted = '0;
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign busy      = (state == ST_SHIFT);
  assign last      = busy & tick & (bit_idx == LAST_IDX);
  assign din_ready = ~rst & ((state == ST_IDLE) | last);
  assign load      = din_ready & din_valid;

  bit_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .clr (load),
    .tick(tick)
  );

  // The register always holds the bit currently on sout at its output end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_idx    <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else if (load) begin
      state      <= ST_SHIFT;
      sreg       <= din;
      bit_idx    <= '0;
      sout       <= out_bit(din);
      sout_valid <= 1'b1;
      sof        <= 1'b1;
      eof        <= 1'b0;
    end else if (last) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_idx    <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else if (busy && tick) begin
      sreg    <= sreg_shifted;
      bit_idx <= bit_idx + 1'b1;
      sout    <= out_bit(sreg_shifted);
      sof     <= 1'b0;
      eof     <= (bit_idx == PEN_IDX);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first single-cycle instance and one LSB-first 3-cycle instance.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_din, b_din;
  logic a_valid, a_ready, a_sout, a_sv, a_sof, a_eof, a_busy;
  logic b_valid, b_ready, b_sout, b_sv, b_sof, b_eof, b_busy;

  piso_serializer #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
    .sout(a_sout), .sout_valid(a_sv), .sof(a_sof), .eof(a_eof), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .BIT_CYCLES(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .sout(b_sout), .sout_valid(b_sv), .sof(b_sof), .eof(b_eof), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string t, input logic s, input logic v, input logic f,
                       input logic e, input logic r);
    chk({t, "_sout"}, a_sout, s);
    chk({t, "_valid"}, a_sv, v);
    chk({t, "_sof"}, a_sof, f);
    chk({t, "_eof"}, a_eof, e);
    chk({t, "_ready"}, a_ready, r);
  endtask

  // End-to-end scoreboard: an 8-stage SISO chain behind dut_a.
  logic [7:0] exp_q[$];
  logic [7:0] chain = '0;
  logic       chain_due = 1'b0;
  logic       t6_on = 1'b0;

  always @(posedge clk) begin
    chain     <= {chain[6:0], a_sout};
    chain_due <= t6_on && a_eof && a_sv;
  end

  always @(negedge clk) begin
    if (chain_due) begin
      chk("t6_q_nonempty", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) chk("t6_chain", chain, exp_q.pop_front());
    end
  end

  initial begin
    logic [7:0] w;
    int n;
    rst = 1'b1;
    a_din = '0; a_valid = 1'b0;
    b_din = '0; b_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_a("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst0_busy", a_busy, 1'b0);
    chk("rst0_b_valid", b_sv, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst0_ready_a", a_ready, 1'b1);
    chk("rst0_ready_b", b_ready, 1'b1);

    // T1: reset in the middle of a frame
    a_din = 8'hFF; a_valid = 1'b1;
    step;
    a_valid = 1'b0;
    repeat (3) step;
    chk("t1_busy_mid", a_busy, 1'b1);
    chk("t1_sout_mid", a_sout, 1'b1);
    rst = 1'b1;
    step;
    chk_a("t1_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_busy", a_busy, 1'b0);
    repeat (2) step;
    rst = 1'b0;
    #1;
    chk("t1_ready_release", a_ready, 1'b1);
    step;
    chk("t1_still_idle", a_sv, 1'b0);

    // T2: single word 8'hA5 -> 1,0,1,0,0,1,0,1
    w = 8'hA5;
    a_din = w; a_valid = 1'b1;
    step;
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t2_b%0d", i), w[7-i], 1'b1, (i == 0), (i == 7), (i == 7));
      chk($sformatf("t2_busy%0d", i), a_busy, 1'b1);
      step;
    end
    chk_a("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_idle_busy", a_busy, 1'b0);

    // T3: back-to-back 8'hFF then 8'h00 with din_valid held
    a_din = 8'hFF; a_valid = 1'b1;
    step;
    for (int i = 0; i < 16; i++) begin
      chk_a($sformatf("t3_c%0d", i), (i < 8), 1'b1, (i == 0 || i == 8), (i == 7 || i == 15),
            (i == 7 || i == 15));
      if (i == 7) a_din = 8'h00;
      if (i == 15) a_valid = 1'b0;
      step;
    end
    chk_a("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // T4: BIT_CYCLES=3, LSB first, 8'h01
    b_din = 8'h01; b_valid = 1'b1;
    chk("t4_ready_idle", b_ready, 1'b1);
    step;
    b_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("t4_sout%0d", i), b_sout, (i < 3));
      chk($sformatf("t4_valid%0d", i), b_sv, 1'b1);
      chk($sformatf("t4_sof%0d", i), b_sof, (i < 3));
      chk($sformatf("t4_eof%0d", i), b_eof, (i >= 21));
      chk($sformatf("t4_ready%0d", i), b_ready, (i == 23));
      step;
    end
    chk("t4_idle_valid", b_sv, 1'b0);
    chk("t4_idle_sout", b_sout, 1'b0);
    chk("t4_idle_busy", b_busy, 1'b0);

    // T5: mid-frame pulses are ignored; the second word waits for din_ready
    w = 8'h3C;
    a_din = w; a_valid = 1'b1;
    step;
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t5_b%0d", i), w[7-i], 1'b1, (i == 0), (i == 7), (i == 7));
      if (i == 2) begin a_din = 8'hC3; a_valid = 1'b1; end
      if (i == 3) a_valid = 1'b0;
      if (i == 5) begin a_din = 8'hC3; a_valid = 1'b1; end
      step;
    end
    a_valid = 1'b0;
    w = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t5_n%0d", i), w[7-i], 1'b1, (i == 0), (i == 7), (i == 7));
      step;
    end
    chk_a("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // T6: 100 random words through the SISO chain, random idle gaps
    t6_on = 1'b1;
    for (int k = 0; k < 100; k++) begin
      w = 8'($urandom_range(0, 255));
      a_din = w; a_valid = 1'b1;
      n = 0;
      while (!a_ready && n < 40) begin
        step;
        n++;
      end
      chk($sformatf("t6_accept%0d", k), a_ready, 1'b1);
      exp_q.push_back(w);
      step;
      n = $urandom_range(0, 3);
      if (n > 0) begin
        a_valid = 1'b0;
        repeat (n) step;
      end
    end
    a_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step;
      n++;
    end
    repeat (2) step;
    chk("t6_drained", exp_q.size(), 0);
    t6_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
